// File: rtl/fetch_pkg.sv
// Shared widths, byte-select encodings and the instruction buffer entry type
// for the prefetching instruction fetch stage.
package fetch_pkg;

  localparam int PC_W       = 8;
  localparam int INSTR_W    = 16;
  localparam int ROM_ADDR_W = 9;

  // byte_sel encoding: the high byte of a word lives at the even ROM address
  localparam logic BYTE_HI = 1'b0;
  localparam logic BYTE_LO = 1'b1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: small synchronous buffer of assembled {instr, pc} entries.
// Latency: an entry written on an edge is visible at the head the following cycle.
// Backpressure: push while full is only legal together with a pop; flush overrides push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = IDX_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  fetch_entry_t     mem [DEPTH];
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] rd_ptr;

  // storage write; entry validity is tracked by count, so the array needs no reset
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + IDX_W'(1);
      if (pop)  rd_ptr <= rd_ptr + IDX_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/instr_fetch_unit.sv
// Purpose: prefetch 16-bit instructions as two ROM bytes and queue {instr, pc} for the core.
// Latency: hi-byte grant in cycle c gives instr_valid in c+3; redirect in r gives earliest instr_valid in r+4.
// Backpressure: a new word is started only when a FIFO slot is reserved for it; instr_ready low fills the FIFO and stops requests.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  rom_req,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic                  rom_gnt,
  input  logic [7:0]            rom_rdata,
  output logic                  instr_valid,
  output logic [INSTR_W-1:0]    instr,
  output logic [PC_W-1:0]       instr_pc,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [PC_W-1:0]       redirect_pc
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  word_pc;
  logic             byte_sel;
  logic [7:0]       hold_hi;
  logic             resp_pending;
  logic             resp_sel;
  logic             word_open;

  logic             credit_ok;
  logic             grant;
  logic             resp_hi;
  logic             resp_lo;
  logic             push;
  logic             pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  // a word already holding a slot reservation counts as occupied
  assign credit_ok = ({1'b0, fifo_count} + SUM_W'(word_open)) < SUM_W'(FIFO_DEPTH);

  assign rom_req  = reset_n && !redirect && ((byte_sel == BYTE_LO) || credit_ok);
  assign rom_addr = {fetch_pc, byte_sel};
  assign grant    = rom_req && rom_gnt;

  // responses landing in a redirect cycle belong to the abandoned stream
  assign resp_hi = resp_pending && !redirect && (resp_sel == BYTE_HI);
  assign resp_lo = resp_pending && !redirect && (resp_sel == BYTE_LO);

  assign instr_valid = !fifo_empty && !redirect;
  assign pop         = instr_valid && instr_ready;
  assign push        = resp_lo && (!fifo_full || pop);

  assign push_entry.instr = {hold_hi, rom_rdata};
  assign push_entry.pc    = word_pc;

  assign instr    = instr_valid ? head.instr : '0;
  assign instr_pc = instr_valid ? head.pc    : '0;

  // request sequencer: hi byte, then lo byte, then advance the fetch PC
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc  <= '0;
      word_pc   <= '0;
      byte_sel  <= BYTE_HI;
      word_open <= 1'b0;
    end else if (redirect) begin
      fetch_pc  <= redirect_pc;
      byte_sel  <= BYTE_HI;
      word_open <= 1'b0;
    end else begin
      if (grant) begin
        if (byte_sel == BYTE_HI) begin
          byte_sel <= BYTE_LO;
        end else begin
          byte_sel <= BYTE_HI;
          word_pc  <= fetch_pc;
          fetch_pc <= fetch_pc + PC_W'(1);
        end
      end
      // a new word opening on the same edge an old one completes keeps the reservation
      if (grant && (byte_sel == BYTE_HI)) begin
        word_open <= 1'b1;
      end else if (resp_lo) begin
        word_open <= 1'b0;
      end
    end
  end

  // track the byte in flight and capture the high byte when it returns
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_pending <= 1'b0;
      resp_sel     <= BYTE_HI;
      hold_hi      <= '0;
    end else if (redirect) begin
      resp_pending <= 1'b0;
      resp_sel     <= BYTE_HI;
    end else begin
      resp_pending <= grant;
      resp_sel     <= byte_sel;
      if (resp_hi) begin
        hold_hi <= rom_rdata;
      end
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect),
    .head       (head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

endmodule
